mem_access_ctrl: RTL
====================

# mem_access_ctrl

Clocked access controller that sits directly upstream of the 8x8 memory array of level-sensitive `MemoryCell` instances. It accepts one read or write request at a time over a valid/ready handshake and decodes the address to a one-hot cell select. It sequences `rw`, `wordIn` and `sel` so the write-enable window is glitch-free, then returns one response per request with read data captured from the selected cell's `wordOut`.

## Interface
- `ADDR_W`, default 3: address width.
- `DATA_W`, default 8: word width.
- `NUM_CELLS`, default 8: number of cells; must equal 2**ADDR_W.

Ports (all outputs registered):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_rw`  in  1  1 = write, 0 = read (same encoding as the cell `rw`).
- `req_addr`  in  ADDR_W  target cell index.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_write`  out  1  response is for a write.
- `rsp_rdata`  out  DATA_W  read data; 0 for write responses.
- `cell_sel`  out  NUM_CELLS  one-hot select, bit i goes to cell i `sel`.
- `cell_rw`  out  1  shared `rw` to all cells.
- `cell_wdata`  out  DATA_W  shared `wordIn` to all cells.
- `cell_rdata`  in  NUM_CELLS*DATA_W  concatenated `wordOut`; cell i occupies bits [i*DATA_W +: DATA_W].

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE:
  - `req_ready`=1, `cell_sel`=0, `cell_rw`=0.
  - On `req_valid & req_ready`, latch rw/addr/wdata and go to SETUP.
- SETUP:
  - `cell_rw` = latched rw; `cell_wdata` = latched wdata for writes, unchanged for reads.
  - `cell_sel`=0. Go to STROBE.
- STROBE:
  - `cell_sel` = one-hot(addr); `cell_rw` and `cell_wdata` unchanged. Go to HOLD.
- HOLD, write:
  - `cell_sel`=0; `cell_rw` still 1 and `cell_wdata` still stable, so the cell closes its write before rw drops. Go to RESP.
- HOLD, read:
  - `cell_sel` remains one-hot.
  - At the end of HOLD, `rsp_rdata` captures the selected slice of `cell_rdata`. Go to RESP.
- RESP:
  - `rsp_valid`=1, `rsp_write` = latched rw; `cell_sel`=0, `cell_rw`=0.
  - Leave to IDLE on the edge where `rsp_ready`=1; `rsp_valid` drops on that edge.
- Invariants:
  - `cell_rw` never changes in any cycle in which any `cell_sel` bit is 1.
  - At most one `cell_sel` bit is high.
  - `cell_sel` is never high outside STROBE and read-HOLD.
- Inputs `req_*` are ignored outside IDLE; they are not queued.
- The read path muxes only the addressed slice; other cells' data never reaches `rsp_rdata`.

## Timing
- Reset values (applied asynchronously on `rst` high):
  - state IDLE; `req_ready`=0; `rsp_valid`=0; `rsp_write`=0; `rsp_rdata`=0; `cell_sel`=0; `cell_rw`=0; `cell_wdata`=0.
  - `req_ready` rises on the first clock edge after `rst` deasserts.
- Accept on edge E0, then SETUP after E0, STROBE after E1, HOLD after E2, `rsp_valid` high after E3.
- Latency is 3 cycles from the accept edge to `rsp_valid`. With `rsp_ready` held high, `req_ready` is high again after E4, giving 5 cycles per transaction minimum.
- `req_ready` is 0 from the edge after accept until return to IDLE.
- `rsp_valid`, `rsp_write` and `rsp_rdata` are stable while `rsp_valid`=1 and `rsp_ready`=0 (unbounded stall allowed).
- `rst` asserted mid-transaction:
  - `cell_sel` clears immediately without waiting for a clock.
  - The in-flight request is dropped with no response.
  - A write interrupted in STROBE may leave the target cell partially updated; other cells must be unaffected.

## Test plan
- Write 0xAA to addr 0, then read addr 0 -> write response with `rsp_write`=1 and `rsp_rdata`=0; read response `rsp_rdata`=0xAA at 3 cycles after accept.
- Write 0xCC to addr 7 and 0x33 to addr 3, then read addrs 7, 3, 5 -> 0xCC, 0x33, 0x00 (5 never written since reset of the array bench). Assert only the addressed `cell_sel` bit ever pulses.
- Read with `rsp_ready` held low for 4 cycles -> `rsp_valid` and `rsp_rdata` held constant; `req_ready`=0 throughout; `req_valid` held high is not accepted until one cycle after the `rsp_ready` edge.
- Every cycle, check that `cell_rw` does not change while `cell_sel`≠0 and that `cell_wdata` is stable during write STROBE/HOLD.
- Assert `rst` asynchronously mid-STROBE of a write of 0x0F to addr 2 (previous value 0xF0) -> `cell_sel`=0 within the same cycle and no `rsp_valid`. After release, a read of addr 4 returns its prior value.
- Back-to-back writes then reads on all 8 addresses with `rsp_ready` tied high -> 16 responses, each 5 cycles apart, all data matching.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Single-outstanding access sequencer for the level-sensitive cell array; 3 cycles accept->rsp_valid.
// Backpressure: req_ready low while a request is in flight; the response holds indefinitely until rsp_ready.
module mem_access_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 8,
    parameter int NUM_CELLS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_rw,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic [NUM_CELLS-1:0]          cell_sel,
    output logic                          cell_rw,
    output logic [DATA_W-1:0]             cell_wdata,
    input  logic [NUM_CELLS*DATA_W-1:0]   cell_rdata
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    state_t                state, state_nxt;
    logic                  lat_rw, lat_rw_nxt;
    logic [ADDR_W-1:0]     lat_addr, lat_addr_nxt;
    logic                  req_ready_nxt, rsp_valid_nxt, rsp_write_nxt, cell_rw_nxt;
    logic [DATA_W-1:0]     rsp_rdata_nxt, cell_wdata_nxt, rd_slice;
    logic [NUM_CELLS-1:0]  cell_sel_nxt, sel_onehot;

    assign sel_onehot = NUM_CELLS'(1) << lat_addr;

    // Only the addressed cell's word is muxed towards the response register.
    always_comb begin
        rd_slice = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (lat_addr == ADDR_W'(i)) rd_slice = cell_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_nxt      = state;
        lat_rw_nxt     = lat_rw;
        lat_addr_nxt   = lat_addr;
        req_ready_nxt  = 1'b0;
        rsp_valid_nxt  = 1'b0;
        rsp_write_nxt  = rsp_write;
        rsp_rdata_nxt  = rsp_rdata;
        cell_sel_nxt   = '0;
        cell_rw_nxt    = cell_rw;
        cell_wdata_nxt = cell_wdata;
        case (state)
            IDLE: begin
                cell_rw_nxt = 1'b0;
                if (req_valid && req_ready) begin
                    lat_rw_nxt   = req_rw;
                    lat_addr_nxt = req_addr;
                    cell_rw_nxt  = req_rw;
                    if (req_rw) cell_wdata_nxt = req_wdata;
                    state_nxt    = SETUP;
                end else begin
                    req_ready_nxt = 1'b1;
                end
            end
            SETUP: begin
                cell_sel_nxt = sel_onehot;
                state_nxt    = STROBE;
            end
            STROBE: begin
                // Writes close the select one cycle before rw drops; reads keep it for capture.
                if (!lat_rw) cell_sel_nxt = sel_onehot;
                state_nxt = HOLD;
            end
            HOLD: begin
                rsp_valid_nxt = 1'b1;
                rsp_write_nxt = lat_rw;
                rsp_rdata_nxt = lat_rw ? '0 : rd_slice;
                cell_rw_nxt   = 1'b0;
                state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    req_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    rsp_valid_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_rw     <= 1'b0;
            lat_addr   <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= '0;
            cell_sel   <= '0;
            cell_rw    <= 1'b0;
            cell_wdata <= '0;
        end else begin
            state      <= state_nxt;
            lat_rw     <= lat_rw_nxt;
            lat_addr   <= lat_addr_nxt;
            req_ready  <= req_ready_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_write  <= rsp_write_nxt;
            rsp_rdata  <= rsp_rdata_nxt;
            cell_sel   <= cell_sel_nxt;
            cell_rw    <= cell_rw_nxt;
            cell_wdata <= cell_wdata_nxt;
        end
    end

endmodule
